// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;
   localparam int UART_DATA_W = 8;
   localparam int BPS_PARA_DEF = 5208;
endpackage

// File: rtl/uart_rx_checker_if.sv
// uart_rx_checker_if: valid/ready byte port between the receiver and its consumer
interface uart_rx_checker_if;
   import uart_pkg::*;
   logic [UART_DATA_W-1:0] data_o;
   logic                   valid_o;
   logic                   ready_i;
   modport master (output data_o, valid_o, input ready_i);
   modport slave (input data_o, valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line with a falling-edge pulse
module uart_rx_sync (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic rx_i,
   output logic rx_s,
   output logic fall
);
   logic [2:0] q;
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) q <= '1;
      else q <= {q[1:0], rx_i};
   assign rx_s = q[1];
   assign fall = q[2] & ~q[1];
endmodule

// File: rtl/uart_rx_checker.sv
// uart_rx_checker: 8N1 UART receiver with holding register; UART_RX_SEQ_CHECK_EN adds a 0..255 pattern checker
module uart_rx_checker
   import uart_pkg::*;
#(
   parameter int BPS_PARA = BPS_PARA_DEF,
   parameter int CNT_W    = 16
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rx_i,
   input  logic              clr_i,
   uart_rx_checker_if.master rx_bus,
   output logic              frame_err_o,
   output logic              overrun_o,
   output logic              seq_err_o,
   output logic [15:0]       seq_err_cnt_o
);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BPS_PARA / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BPS_PARA - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   rx_state_e              state;
   logic [CNT_W-1:0]       cnt;
   logic [2:0]             idx;
   logic [UART_DATA_W-1:0] shift;
   logic                   rx_s, fall, tick, done, ferr, load, drop;
   uart_rx_sync u_sync (.clk_in(clk_in), .rst_n_in(rst_n_in), .rx_i(rx_i), .rx_s(rx_s), .fall(fall));
   assign tick = cnt == BIT_M1;
   assign done = state == STOP && tick && rx_s;
   assign ferr = state == STOP && tick && !rx_s;
   assign load = done && (!rx_bus.valid_o || rx_bus.ready_i);
   assign drop = done && !load;
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               idx <= '0;
               if (fall) state <= START;
            end
            START:
               if (cnt == HALF_M1) begin
                  cnt   <= '0;
                  state <= rx_s ? IDLE : DATA;
               end else cnt <= cnt + ONE;
            DATA:
               if (tick) begin
                  cnt   <= '0;
                  shift <= {rx_s, shift[UART_DATA_W-1:1]};
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7) state <= STOP;
               end else cnt <= cnt + ONE;
            STOP:
               if (tick) begin
                  cnt   <= '0;
                  state <= rx_s ? IDLE : WAIT_IDLE;
               end else cnt <= cnt + ONE;
            WAIT_IDLE: if (rx_s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   // Sticky flags: a same-cycle error event overrides clr_i
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         rx_bus.data_o  <= '0;
         rx_bus.valid_o <= 1'b0;
         frame_err_o    <= 1'b0;
         overrun_o      <= 1'b0;
      end else begin
         if (load) begin
            rx_bus.data_o  <= shift;
            rx_bus.valid_o <= 1'b1;
         end else if (rx_bus.valid_o && rx_bus.ready_i) rx_bus.valid_o <= 1'b0;
         frame_err_o <= ferr | (frame_err_o & ~clr_i);
         overrun_o   <= drop | (overrun_o & ~clr_i);
      end
`ifdef UART_RX_SEQ_CHECK_EN
   logic [UART_DATA_W-1:0] ref_q;
   logic                   has_ref;
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         ref_q         <= '0;
         has_ref       <= 1'b0;
         seq_err_o     <= 1'b0;
         seq_err_cnt_o <= '0;
      end else begin
         seq_err_o <= 1'b0;
         if (load) begin
            if (has_ref && shift != ref_q + 8'd1) begin
               seq_err_o     <= 1'b1;
               seq_err_cnt_o <= &seq_err_cnt_o ? seq_err_cnt_o : seq_err_cnt_o + 16'd1;
            end
            ref_q   <= shift;
            has_ref <= 1'b1;
         end else if (clr_i) begin
            has_ref       <= 1'b0;
            seq_err_cnt_o <= '0;
         end
      end
`else
   assign seq_err_o     = 1'b0;
   assign seq_err_cnt_o = '0;
`endif
endmodule
